// File: rtl/cpu_run_ctrl_pkg.sv
// Shared constants for the CPU run controller: mode codes and FSM states.
package cpu_run_ctrl_pkg;

    localparam logic [1:0] MODE_STEP = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_FAST = 2'b10;
    localparam logic [1:0] MODE_FULL = 2'b11;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_SWITCH = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ce_prescaler.sv
// Free-running divider with runtime terminal count; one-cycle tick at tc.
module ce_prescaler #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] tc,
    output logic         tick
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en)
            count <= (count == tc) ? '0 : count + 1'b1;
    end

    assign tick = en & (count == tc);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Single-clock run controller: issues cpu_ce per mode, halts on PC breakpoint.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int SLOW_DIV = 50_000_000,
    parameter int FAST_DIV = 5_000_000,
    parameter int PC_W     = 12
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [1:0]      mode,
    input  logic            step_n,
    input  logic            resume,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc_addr,
    output logic            cpu_ce,
    output logic            halted,
    output logic [1:0]      mode_active
);

    localparam int PS_RAW = $clog2(max_int(SLOW_DIV, FAST_DIV));
    localparam int PS_W   = (PS_RAW < 1) ? 1 : PS_RAW;
    localparam logic [PS_W-1:0] SLOW_TC = PS_W'(SLOW_DIV - 1);
    localparam logic [PS_W-1:0] FAST_TC = PS_W'(FAST_DIV - 1);

    logic [1:0]      mode_m, mode_s;
    logic [1:0]      state, state_next;
    logic [1:0]      active_next;
    logic            step_prev, step_fall;
    logic            ce_q, ce_next;
    logic            bp_armed, arm_next, bp_hit;
    logic            pending, pending_next;
    logic            mode_chg, halt_entry;
    logic            ps_clear, ps_en, ps_tick;
    logic [PS_W-1:0] ps_tc;

    ce_prescaler #(.W(PS_W)) u_ps (
        .clk   (clk),
        .nrst  (nrst),
        .clear (ps_clear),
        .en    (ps_en),
        .tc    (ps_tc),
        .tick  (ps_tick)
    );

    assign step_fall = step_prev & ~step_n;
    assign bp_hit    = bp_en & bp_armed & (pc_addr == bp_addr);
    assign mode_chg  = (mode_s != mode_active);
    assign ps_tc     = (mode_active == MODE_SLOW) ? SLOW_TC : FAST_TC;
    assign cpu_ce    = ce_q & ~bp_hit;
    assign halted    = (state == ST_HALT);

    always_comb begin
        state_next   = state;
        active_next  = mode_active;
        pending_next = pending;
        ce_next      = 1'b0;
        ps_clear     = 1'b0;
        ps_en        = 1'b0;
        halt_entry   = 1'b0;
        case (state)
            ST_RUN: begin
                if (mode_chg) begin
                    state_next = ST_SWITCH;
                end else if (bp_hit) begin
                    state_next = ST_HALT;
                    halt_entry = 1'b1;
                end else begin
                    unique case (mode_active)
                        MODE_STEP: ce_next = step_fall;
                        MODE_SLOW,
                        MODE_FAST: begin
                            ps_en   = 1'b1;
                            ce_next = ps_tick;
                        end
                        MODE_FULL: ce_next = 1'b1;
                    endcase
                end
            end
            ST_SWITCH: begin
                active_next  = mode_s;
                ps_clear     = 1'b1;
                pending_next = 1'b0;
                halt_entry   = pending;
                state_next   = pending ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                if (mode_chg) begin
                    state_next   = ST_SWITCH;
                    pending_next = 1'b1;
                end else if (resume) begin
                    state_next = ST_RUN;
                    ps_clear   = 1'b1;
                end else begin
                    ce_next = step_fall;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Leaving the breakpoint address re-arms; entering HALT disarms.
    assign arm_next = (pc_addr != bp_addr) ? 1'b1 :
                      halt_entry ? 1'b0 : bp_armed;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_m      <= MODE_STEP;
            mode_s      <= MODE_STEP;
            mode_active <= MODE_STEP;
            state       <= ST_RUN;
            step_prev   <= 1'b1;
            ce_q        <= 1'b0;
            bp_armed    <= 1'b1;
            pending     <= 1'b0;
        end else begin
            mode_m      <= mode;
            mode_s      <= mode_m;
            mode_active <= active_next;
            state       <= state_next;
            step_prev   <= step_n;
            ce_q        <= ce_next;
            bp_armed    <= arm_next;
            pending     <= pending_next;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed, table-driven check of cpu_run_ctrl with small dividers.
module tb_cpu_run_ctrl;

    localparam int PC_W = 12;

    logic            clk;
    logic            nrst;
    logic [1:0]      mode;
    logic            step_n;
    logic            resume;
    logic            bp_en;
    logic [PC_W-1:0] bp_addr;
    logic [PC_W-1:0] pc_addr;
    logic            cpu_ce;
    logic            halted;
    logic [1:0]      mode_active;

    int  n_chk;
    int  n_fail;
    bit  track;
    bit  ce_pre;
    int  cnt;

    typedef struct {
        logic step_n;
        logic ce;
    } vec_t;

    vec_t tv[18];

    cpu_run_ctrl #(
        .SLOW_DIV (10),
        .FAST_DIV (4),
        .PC_W     (PC_W)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .mode        (mode),
        .step_n      (step_n),
        .resume      (resume),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc_addr     (pc_addr),
        .cpu_ce      (cpu_ce),
        .halted      (halted),
        .mode_active (mode_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; a simple CPU model advances pc when cpu_ce was high.
    task automatic cyc();
        @(negedge clk);
        ce_pre = cpu_ce;
        @(posedge clk);
        #1;
        if (track && ce_pre)
            pc_addr = pc_addr + 1'b1;
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        track   = 0;
        nrst    = 1'b0;
        mode    = 2'b00;
        step_n  = 1'b1;
        resume  = 1'b0;
        bp_en   = 1'b0;
        bp_addr = 12'h005;
        pc_addr = 12'h000;

        for (int i = 0; i < 18; i++) begin
            tv[i].step_n = (i == 1 || i == 7 || i == 13) ? 1'b0 : 1'b1;
            tv[i].ce     = (i == 1 || i == 7 || i == 13) ? 1'b1 : 1'b0;
        end

        #1;
        chk("reset_ce", 32'(cpu_ce), 0);
        chk("reset_halted", 32'(halted), 0);
        chk("reset_mode", 32'(mode_active), 0);
        repeat (2) @(posedge clk);
        #2;
        nrst = 1'b1;
        cyc();
        cyc();

        // Step mode: three falls, each one cycle later a single pulse.
        for (int i = 0; i < 18; i++) begin
            step_n = tv[i].step_n;
            cyc();
            chk($sformatf("step_vec%0d", i), 32'(cpu_ce), 32'(tv[i].ce));
        end

        step_n = 1'b0;
        cnt = 0;
        repeat (21) begin
            cyc();
            cnt += int'(cpu_ce);
        end
        step_n = 1'b1;
        chk("step_hold_pulses", cnt, 1);
        cyc();

        // Slow mode: 2 sync flops, detect, SWITCH, then period 10.
        mode = 2'b01;
        repeat (3) cyc();
        chk("slow_not_yet", 32'(mode_active), 0);
        cyc();
        chk("slow_active", 32'(mode_active), 1);
        for (int i = 1; i <= 30; i++) begin
            cyc();
            chk($sformatf("slow_c%0d", i), 32'(cpu_ce),
                32'((i % 10) == 0));
        end

        // Fast mode, period 4.
        mode = 2'b10;
        repeat (3) cyc();
        chk("fast_not_yet", 32'(mode_active), 1);
        cyc();
        chk("fast_active", 32'(mode_active), 2);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk($sformatf("fast_c%0d", i), 32'(cpu_ce),
                32'((i % 4) == 0));
        end

        // Switch to full speed so detection lands at prescaler 2.
        mode = 2'b11;
        cyc();
        chk("full_sw_c1", 32'(cpu_ce), 0);
        cyc();
        chk("full_sw_c2", 32'(cpu_ce), 0);
        cyc();
        chk("full_sw_c3", 32'(cpu_ce), 0);
        chk("full_sw_mode_old", 32'(mode_active), 2);
        cyc();
        chk("full_sw_c4", 32'(cpu_ce), 0);
        chk("full_sw_mode_new", 32'(mode_active), 3);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("full_hi%0d", i), 32'(cpu_ce), 1);
        end

        // Breakpoint disabled: pc on bp_addr never halts.
        pc_addr = 12'h005;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("bpoff_halt%0d", i), 32'(halted), 0);
            chk($sformatf("bpoff_ce%0d", i), 32'(cpu_ce), 1);
        end

        // Breakpoint at 0x005 with pc counting on cpu_ce.
        pc_addr = 12'h000;
        bp_en   = 1'b1;
        track   = 1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_pc%0d", i), 32'(pc_addr), i);
            chk($sformatf("bp_ce%0d", i), 32'(cpu_ce), 1);
            cyc();
        end
        chk("bp_pc5", 32'(pc_addr), 5);
        chk("bp_ce_gated", 32'(cpu_ce), 0);
        chk("bp_not_halted_yet", 32'(halted), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("bp_halted%0d", i), 32'(halted), 1);
            chk($sformatf("bp_halt_ce%0d", i), 32'(cpu_ce), 0);
        end
        chk("bp_pc_hold", 32'(pc_addr), 5);

        // Single step off the breakpoint.
        step_n = 1'b0;
        cyc();
        step_n = 1'b1;
        chk("hstep_ce", 32'(cpu_ce), 1);
        chk("hstep_halted", 32'(halted), 1);
        cyc();
        chk("hstep_pc", 32'(pc_addr), 6);
        chk("hstep_ce_off", 32'(cpu_ce), 0);
        chk("hstep_halted2", 32'(halted), 1);
        cyc();
        chk("hstep_ce_off2", 32'(cpu_ce), 0);

        // Resume, then force pc back onto the re-armed breakpoint.
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        chk("res_halted", 32'(halted), 0);
        chk("res_ce0", 32'(cpu_ce), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("res_ce%0d", i + 1), 32'(cpu_ce), 1);
        end
        pc_addr = 12'h005;
        #1;
        chk("rebp_ce", 32'(cpu_ce), 0);
        cyc();
        chk("rebp_halted", 32'(halted), 1);
        chk("rebp_pc", 32'(pc_addr), 5);

        // Mode change and resume together in HALT: resume dropped.
        mode = 2'b10;
        cyc();
        cyc();
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        chk("mr_switch_halted", 32'(halted), 0);
        chk("mr_switch_mode", 32'(mode_active), 3);
        cyc();
        chk("mr_halted", 32'(halted), 1);
        chk("mr_mode", 32'(mode_active), 2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("mr_stay%0d", i), 32'(halted), 1);
            chk($sformatf("mr_ce%0d", i), 32'(cpu_ce), 0);
        end

        // Back to full speed, then async reset mid-run.
        track = 0;
        bp_en = 1'b0;
        mode  = 2'b11;
        repeat (4) cyc();
        chk("rst_pre_halted", 32'(halted), 1);
        chk("rst_pre_mode", 32'(mode_active), 3);
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        cyc();
        cyc();
        chk("rst_pre_ce", 32'(cpu_ce), 1);
        #2;
        nrst = 1'b0;
        #1;
        chk("rst_async_ce", 32'(cpu_ce), 0);
        chk("rst_async_mode", 32'(mode_active), 0);
        chk("rst_async_halted", 32'(halted), 0);
        repeat (2) @(posedge clk);
        #2;
        nrst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
